// File: rtl/dvma_arbiter.sv
// DVMA bus arbiter: NCH channels, fixed or round-robin priority,
// 68k bus request/grant handshake and system-bus deadlock timeout.
module dvma_arbiter #(
    parameter int NCH = 4,
    parameter bit RR  = 1'b1,
    parameter int TMO = 16
) (
    input  logic           CLK,
    input  logic           RESET_n,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] sup,
    input  logic           p_bg,
    input  logic           sas,
    input  logic           sack,
    input  logic           sysb,
    output logic           p_br,
    output logic           p_back,
    output logic [NCH-1:0] grant,
    output logic           p_as,
    output logic           fc1,
    output logic           xhalt,
    output logic           xberr
);

    localparam int IW = $clog2(NCH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_OWN,
        S_REL
    } state_t;

    state_t          r_state;
    state_t          w_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic            r_acked;
    logic [7:0]      r_cnt;
    logic            r_p_br;
    logic            r_p_back;
    logic [NCH-1:0]  r_grant;
    logic            r_p_as;
    logic            r_fc1;
    logic            r_xhalt;
    logic            r_xberr;

    logic            w_any;
    logic            w_found;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_win;
    logic            w_gnt;
    logic [IW-1:0]   w_own_n;
    logic [NCH-1:0]  w_oh;
    logic            w_in_req;

    assign w_any    = |req;
    assign w_in_req = (r_state == S_REQ);
    assign w_gnt    = w_in_req && w_any && p_bg && !sas;
    assign w_own_n  = w_gnt ? w_win : r_owner;
    assign w_oh     = NCH'(1) << w_own_n;

    // Round-robin scans from the slot after the last owner.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (RR)
                w_idx = IW'((32'(r_ptr) + 32'(i) + 32'd1) % NCH);
            else
                w_idx = IW'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_any) w_nxt = S_REQ;
            S_REQ: begin
                if (!w_any)
                    w_nxt = S_IDLE;
                else if (w_gnt)
                    w_nxt = S_OWN;
            end
            S_OWN: if (!req[r_owner]) w_nxt = S_REL;
            S_REL: w_nxt = w_any ? S_REQ : S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_ptr    <= IW'(NCH - 1);
            r_acked  <= 1'b0;
            r_cnt    <= '0;
            r_p_br   <= 1'b0;
            r_p_back <= 1'b0;
            r_grant  <= '0;
            r_p_as   <= 1'b0;
            r_fc1    <= 1'b0;
            r_xhalt  <= 1'b0;
            r_xberr  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_gnt)
                r_owner <= w_win;
            if (r_state == S_REL)
                r_ptr <= r_owner;
            if (w_gnt)
                r_acked <= 1'b0;
            else if (r_state == S_OWN && sack)
                r_acked <= 1'b1;

            r_p_br   <= (w_nxt == S_REQ);
            r_p_back <= (w_nxt == S_OWN);
            r_grant  <= (w_nxt == S_OWN) ? w_oh : '0;
            r_fc1    <= (w_nxt == S_OWN) && sup[w_own_n];
            r_p_as   <= w_gnt ||
                        (r_state == S_OWN && w_nxt == S_OWN &&
                         !sack && !r_acked);

            // Halt/berr hold until the bus strobe is released.
            if (r_xhalt && !sas) begin
                r_xhalt <= 1'b0;
                r_xberr <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_xberr <= r_xhalt;
                if (!r_xhalt && w_in_req && !w_gnt &&
                    r_cnt == 8'(TMO))
                    r_xhalt <= 1'b1;
                if (w_in_req && w_nxt == S_REQ && sysb)
                    r_cnt <= (r_cnt == 8'(TMO)) ? r_cnt : r_cnt + 8'd1;
                else
                    r_cnt <= '0;
            end
        end
    end

    assign p_br   = r_p_br;
    assign p_back = r_p_back;
    assign grant  = r_grant;
    assign p_as   = r_p_as;
    assign fc1    = r_fc1;
    assign xhalt  = r_xhalt;
    assign xberr  = r_xberr;

endmodule
